// File: rtl/hazard_ctrl_sb.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_sb
//
// Hazard / forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
// It sits beside the datapath and drives every forward select, stall line and
// flush line. Besides classic forwarding and load-use/branch interlocks it holds:
//   - a register scoreboard for long-latency results (load, HILO, CP0 read)
//     that are still in M and cannot yet feed a D-stage branch compare,
//   - outstanding-transaction counters for the instruction and data buses,
//   - an exception drain FSM (RUN/DRAIN) that drops data responses belonging
//     to flushed accesses,
//   - a stall watchdog with a sticky timeout flag.
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   defined     -> perf_mem/perf_mdu/perf_haz count stall cycles per cause
//   not defined -> counters are not built, perf_* read as 0
//
// Ports
//   clock, reset                     clock, asynchronous active-low reset
//   rs_d, rt_d, use_rs_d, use_rt_d   D-stage sources and "actually read" flags
//   branch_d                         D holds a branch/jr compared in D
//   rs_e, rt_e                       E-stage sources
//   write_reg_e, reg_write_e,
//   long_lat_e                       E destination, write enable, long-latency op
//   write_reg_m, reg_write_m,
//   exception_m                      M destination, write enable, exception
//   write_reg_w, reg_write_w         W destination, write enable
//   mdu_busy                         mul/div unit iterating
//   inst_req_ok, inst_data_ok        instruction bus request accepted / response
//   data_req_ok, data_data_ok        data bus request accepted / response
//   fwd_a_e, fwd_b_e                 E operand select: 10=M, 01=W, 00=regfile
//   fwd_a_d, fwd_b_d                 D compare operand from M result
//   stall_f..stall_w                 hold stage register
//   flush_d..flush_w                 clear stage register
//   exc_pc_sel_f                     select exception vector for the PC
//   discard_data                     drop the current data response
//   stall_timeout                    sticky watchdog flag
//   perf_mem, perf_mdu, perf_haz     stall-cycle counters
// -----------------------------------------------------------------------------
module hazard_ctrl_sb #(
    parameter int REG_W         = 5,
    parameter int NUM_REGS      = 32,
    parameter int MAX_OUT       = 2,
    parameter int OUT_W         = 2,
    parameter int STALL_TIMEOUT = 1024,
    parameter int TO_W          = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_d,
    input  logic [REG_W-1:0]  rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic              branch_d,
    input  logic [REG_W-1:0]  rs_e,
    input  logic [REG_W-1:0]  rt_e,
    input  logic [REG_W-1:0]  write_reg_e,
    input  logic              reg_write_e,
    input  logic              long_lat_e,
    input  logic [REG_W-1:0]  write_reg_m,
    input  logic              reg_write_m,
    input  logic              exception_m,
    input  logic [REG_W-1:0]  write_reg_w,
    input  logic              reg_write_w,
    input  logic              mdu_busy,
    input  logic              inst_req_ok,
    input  logic              inst_data_ok,
    input  logic              data_req_ok,
    input  logic              data_data_ok,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              stall_w,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              exc_pc_sel_f,
    output logic              discard_data,
    output logic              stall_timeout,
    output logic [31:0]       perf_mem,
    output logic [31:0]       perf_mdu,
    output logic [31:0]       perf_haz
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     inst_out_q, inst_out_d;
    logic [OUT_W-1:0]     data_out_q, data_out_d;
    logic [NUM_REGS-1:0]  sb_q, sb_d;
    logic [TO_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 timeout_q, timeout_d;

    logic                 mem_stall;
    logic                 haz_stall;
    logic                 wd_full;

    // E-stage operand select: M result has priority over W result.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (src != '0 && src == write_reg_m && reg_write_m) begin
            return 2'b10;
        end else if (src != '0 && src == write_reg_w && reg_write_w) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // One D-stage source: hazard against a not-yet-forwardable producer in E,
    // or (for branches) against a long-latency result still sitting in M.
    function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                        input logic             used);
        logic e_hit;
        e_hit = (src == write_reg_e) && reg_write_e && (branch_d || long_lat_e);
        return used && (src != '0) && (e_hit || (branch_d && sb_q[src]));
    endfunction

    // Outstanding counter update. Request and response together cancel; a
    // request at MAX_OUT or a response at zero is a protocol error and is ignored.
    function automatic logic [OUT_W-1:0] out_next(input logic [OUT_W-1:0] cnt,
                                                  input logic             req,
                                                  input logic             rsp);
        if (req && rsp) begin
            return cnt;
        end else if (req && cnt != OUT_W'(MAX_OUT)) begin
            return cnt + OUT_W'(1);
        end else if (rsp && cnt != '0) begin
            return cnt - OUT_W'(1);
        end
        return cnt;
    endfunction

    assign mem_stall = (data_out_q != '0) || (inst_out_q != '0);
    assign haz_stall = src_hazard(rs_d, use_rs_d) || src_hazard(rt_d, use_rt_d);
    assign wd_full   = (wd_cnt_q == TO_W'(STALL_TIMEOUT));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            inst_out_q <= '0;
            data_out_q <= '0;
            sb_q       <= '0;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            sb_q       <= sb_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (exception_m && data_out_q != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last flushed response has arrived,
                // counting the response of this very cycle.
                if (!exception_m && data_out_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        inst_out_d = out_next(inst_out_q, inst_req_ok, inst_data_ok);
        data_out_d = out_next(data_out_q, data_req_ok, data_data_ok);
    end

    // Scoreboard. A hazard bubble (flush_e raised for a D-stage hazard) clears
    // what enters E next, not the long-latency op already in E, so only an
    // exception kills the E-stage write here. The set is applied after the
    // clear so that a set and clear of the same register keeps the bit.
    always_comb begin
        sb_d = sb_q;
        if (!stall_m) begin
            sb_d[write_reg_m] = 1'b0;
        end
        if (reg_write_e && long_lat_e && write_reg_e != '0 && !stall_e && !exception_m) begin
            sb_d[write_reg_e] = 1'b1;
        end
        if (exception_m) begin
            sb_d = '0;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        if (!stall_f) begin
            wd_cnt_d = '0;
        end else if (wd_full) begin
            wd_cnt_d = wd_cnt_q;
        end else begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
        end
        timeout_d = timeout_q | wd_full;
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        fwd_a_e       = 2'b00;
        fwd_b_e       = 2'b00;
        fwd_a_d       = 1'b0;
        fwd_b_d       = 1'b0;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        stall_w       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        flush_w       = 1'b0;
        exc_pc_sel_f  = 1'b0;
        discard_data  = 1'b0;
        stall_timeout = 1'b0;
        if (reset) begin
            fwd_a_e = fwd_sel(rs_e);
            fwd_b_e = fwd_sel(rt_e);
            fwd_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
            fwd_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;

            if (exception_m) begin
                flush_d      = 1'b1;
                flush_e      = 1'b1;
                flush_m      = 1'b1;
                flush_w      = 1'b1;
                exc_pc_sel_f = 1'b1;
                stall_f      = (state_q == ST_DRAIN);
            end else if (state_q == ST_DRAIN) begin
                // Redirected PC is held until flushed data responses are gone;
                // the rest of the pipeline only carries bubbles.
                stall_f = 1'b1;
            end else if (mem_stall || mdu_busy) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                stall_w = 1'b1;
            end else if (haz_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end

            discard_data  = (state_q == ST_DRAIN) && data_data_ok;
            stall_timeout = timeout_q | wd_full;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_mem_q, perf_mem_d;
    logic [31:0] perf_mdu_q, perf_mdu_d;
    logic [31:0] perf_haz_q, perf_haz_d;

    // Each stall cycle is charged to its highest-priority cause only;
    // exception cycles are not charged. Counters wrap naturally.
    always_comb begin
        perf_mem_d = perf_mem_q;
        perf_mdu_d = perf_mdu_q;
        perf_haz_d = perf_haz_q;
        if (!exception_m) begin
            if (mem_stall) begin
                perf_mem_d = perf_mem_q + 32'd1;
            end else if (mdu_busy) begin
                perf_mdu_d = perf_mdu_q + 32'd1;
            end else if (haz_stall) begin
                perf_haz_d = perf_haz_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_mem_q <= '0;
            perf_mdu_q <= '0;
            perf_haz_q <= '0;
        end else begin
            perf_mem_q <= perf_mem_d;
            perf_mdu_q <= perf_mdu_d;
            perf_haz_q <= perf_haz_d;
        end
    end

    assign perf_mem = perf_mem_q;
    assign perf_mdu = perf_mdu_q;
    assign perf_haz = perf_haz_q;
`else
    assign perf_mem = 32'd0;
    assign perf_mdu = 32'd0;
    assign perf_haz = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;

    localparam int TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic        use_rs_d, use_rt_d, branch_d, reg_write_e, long_lat_e;
    logic        reg_write_m, exception_m, reg_write_w, mdu_busy;
    logic        inst_req_ok, inst_data_ok, data_req_ok, data_data_ok;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        fwd_a_d, fwd_b_d;
    logic        stall_f, stall_d, stall_e, stall_m, stall_w;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        exc_pc_sel_f, discard_data, stall_timeout;
    logic [31:0] perf_mem, perf_mdu, perf_haz;
    logic [17:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int        m_inst, m_data, m_wd;
    bit        m_drain, m_to;
    bit [31:0] m_sb;

    hazard_ctrl_sb dut (
        .clock(clock), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .branch_d(branch_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .long_lat_e(long_lat_e),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .exception_m(exception_m),
        .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .mdu_busy(mdu_busy),
        .inst_req_ok(inst_req_ok), .inst_data_ok(inst_data_ok),
        .data_req_ok(data_req_ok), .data_data_ok(data_data_ok),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .flush_w(flush_w), .exc_pc_sel_f(exc_pc_sel_f), .discard_data(discard_data),
        .stall_timeout(stall_timeout), .perf_mem(perf_mem), .perf_mdu(perf_mdu),
        .perf_haz(perf_haz)
    );

    always #5 clock = ~clock;

    assign obs = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, stall_m,
                  stall_w, flush_d, flush_e, flush_m, flush_w, exc_pc_sel_f, discard_data,
                  stall_timeout};

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        use_rs_d = 0; use_rt_d = 0; branch_d = 0; reg_write_e = 0; long_lat_e = 0;
        reg_write_m = 0; exception_m = 0; reg_write_w = 0; mdu_busy = 0;
        inst_req_ok = 0; inst_data_ok = 0; data_req_ok = 0; data_data_ok = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    // ------------------------------------------------------------------ model
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src != 0 && src == write_reg_m && reg_write_m) return 2'b10;
        if (src != 0 && src == write_reg_w && reg_write_w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_src_haz(input logic [4:0] src, input bit used);
        if (!used || src == 0) return 1'b0;
        if (src == write_reg_e && reg_write_e && (branch_d || long_lat_e)) return 1'b1;
        return branch_d && m_sb[src];
    endfunction

    task automatic model_reset();
        m_inst = 0; m_data = 0; m_wd = 0; m_drain = 0; m_to = 0; m_sb = '0;
    endtask

    task automatic model_outputs(output logic [17:0] e, output bit sf, output bit se,
                                 output bit sm);
        bit mem, haz, sd, sw, fd, fe, fm, fw, ex, dd, to;
        mem = (m_inst > 0) || (m_data > 0);
        haz = m_src_haz(rs_d, use_rs_d) || m_src_haz(rt_d, use_rt_d);
        {sf, sd, se, sm, sw, fd, fe, fm, fw, ex} = '0;
        if (exception_m) begin
            {fd, fe, fm, fw, ex} = 5'b11111;
            sf = m_drain;
        end else if (m_drain) begin
            sf = 1;
        end else if (mem || mdu_busy) begin
            {sf, sd, se, sm, sw} = 5'b11111;
        end else if (haz) begin
            sf = 1; sd = 1; fe = 1;
        end
        dd = m_drain && data_data_ok;
        to = m_to || (m_wd >= TIMEOUT);
        e = {m_fwd(rs_e), m_fwd(rt_e),
             rs_d != 0 && rs_d == write_reg_m && reg_write_m,
             rt_d != 0 && rt_d == write_reg_m && reg_write_m,
             sf, sd, se, sm, sw, fd, fe, fm, fw, ex, dd, to};
    endtask

    task automatic model_step(input bit sf, input bit se, input bit sm);
        int old_data;
        old_data = m_data;
        if (!(inst_req_ok && inst_data_ok)) begin
            if (inst_req_ok && m_inst < 2) m_inst++;
            else if (inst_data_ok && m_inst > 0) m_inst--;
        end
        if (!(data_req_ok && data_data_ok)) begin
            if (data_req_ok && m_data < 2) m_data++;
            else if (data_data_ok && m_data > 0) m_data--;
        end
        if (exception_m) m_sb = '0;
        else begin
            if (!sm) m_sb[write_reg_m] = 0;
            if (reg_write_e && long_lat_e && write_reg_e != 0 && !se) m_sb[write_reg_e] = 1;
        end
        if (!m_drain) m_drain = exception_m && old_data > 0;
        else m_drain = exception_m || m_data > 0;
        if (m_wd >= TIMEOUT) m_to = 1;
        m_wd = sf ? ((m_wd < TIMEOUT) ? m_wd + 1 : m_wd) : 0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        idle();
        reset = 1'b0;
        rs_e = 3; write_reg_m = 3; reg_write_m = 1; exception_m = 1; mdu_busy = 1;
        #1;
        n_checks++;
        if (obs !== 18'd0) $display("FAIL reset_outputs: got %b required 0", obs);
        else n_pass++;
        tick();
        idle();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({stall_f, stall_m, stall_timeout, discard_data} !== 4'b0)
            $display("FAIL reset_idle: got %b required 0000",
                     {stall_f, stall_m, stall_timeout, discard_data});
        else n_pass++;
    endtask

    task automatic test_forwarding();
        do_reset();
        rs_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1;
        #1;
        n_checks++;
        if (fwd_a_e !== 2'b10) $display("FAIL fwd_a_e_m: got %b required 10", fwd_a_e);
        else n_pass++;
        rs_e = 0;
        #1;
        n_checks++;
        if (fwd_a_e !== 2'b00) $display("FAIL fwd_a_e_r0: got %b required 00", fwd_a_e);
        else n_pass++;
        rs_e = 3; reg_write_m = 0;
        #1;
        n_checks++;
        if (fwd_a_e !== 2'b01) $display("FAIL fwd_a_e_w: got %b required 01", fwd_a_e);
        else n_pass++;
        rt_e = 3; reg_write_m = 1; reg_write_w = 0;
        #1;
        n_checks++;
        if (fwd_b_e !== 2'b10) $display("FAIL fwd_b_e_m: got %b required 10", fwd_b_e);
        else n_pass++;
        rs_d = 3; rt_d = 4;
        #1;
        n_checks++;
        if ({fwd_a_d, fwd_b_d} !== 2'b10) $display("FAIL fwd_d: got %b required 10", {fwd_a_d, fwd_b_d});
        else n_pass++;
        reg_write_m = 0;
        #1;
        n_checks++;
        if ({fwd_a_d, fwd_b_d} !== 2'b00) $display("FAIL fwd_d_nowrite: got %b required 00", {fwd_a_d, fwd_b_d});
        else n_pass++;
    endtask

    task automatic test_load_branch();
        do_reset();
        write_reg_e = 5; reg_write_e = 1; long_lat_e = 1;
        rs_d = 5; use_rs_d = 1; branch_d = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, stall_e, flush_e} !== 4'b1101)
            $display("FAIL lb_load_in_e: got %b required 1101", {stall_f, stall_d, stall_e, flush_e});
        else n_pass++;
        tick();
        write_reg_e = 0; reg_write_e = 0; long_lat_e = 0;
        write_reg_m = 5; reg_write_m = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, stall_e, flush_e} !== 4'b1101)
            $display("FAIL lb_load_in_m: got %b required 1101", {stall_f, stall_d, stall_e, flush_e});
        else n_pass++;
        tick();
        write_reg_m = 0; reg_write_m = 0; write_reg_w = 5; reg_write_w = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b000)
            $display("FAIL lb_load_in_w: got %b required 000", {stall_f, stall_d, flush_e});
        else n_pass++;
        // non-branch load-use, then source register 0
        idle();
        write_reg_e = 7; reg_write_e = 1; long_lat_e = 1; rt_d = 7; use_rt_d = 1;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b111)
            $display("FAIL load_use: got %b required 111", {stall_f, stall_d, flush_e});
        else n_pass++;
        write_reg_e = 0; rt_d = 0;
        #1;
        n_checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b000)
            $display("FAIL load_use_r0: got %b required 000", {stall_f, stall_d, flush_e});
        else n_pass++;
    endtask

    task automatic test_outstanding();
        do_reset();
        data_req_ok = 1; tick(); tick();
        data_req_ok = 0; data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if ({stall_f, stall_m} !== 2'b11) $display("FAIL out_one_left: got %b required 11", {stall_f, stall_m});
        else n_pass++;
        data_req_ok = 1; data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b1) $display("FAIL out_req_rsp_same: got %b required 1", stall_m);
        else n_pass++;
        data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b0) $display("FAIL out_drained: got %b required 0", stall_m);
        else n_pass++;
        data_req_ok = 1; tick(); tick(); tick();
        data_req_ok = 0; data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b1) $display("FAIL out_sat_first: got %b required 1", stall_m);
        else n_pass++;
        data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b0) $display("FAIL out_saturated: got %b required 0", stall_m);
        else n_pass++;
        data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b0) $display("FAIL out_underflow: got %b required 0", stall_m);
        else n_pass++;
        inst_req_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if ({stall_f, stall_w} !== 2'b11) $display("FAIL inst_out: got %b required 11", {stall_f, stall_w});
        else n_pass++;
        inst_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_f !== 1'b0) $display("FAIL inst_out_done: got %b required 0", stall_f);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_req_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_m !== 1'b1) $display("FAIL mid_before: got %b required 1", stall_m);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 18'd0) $display("FAIL mid_async: got %b required 0", obs);
        else n_pass++;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall_m !== 1'b0) $display("FAIL mid_cleared: got %b required 0", stall_m);
        else n_pass++;
    endtask

    task automatic test_drain();
        do_reset();
        data_req_ok = 1; tick();
        idle(); exception_m = 1;
        #1;
        n_checks++;
        if ({flush_d, flush_e, flush_m, flush_w, exc_pc_sel_f, stall_f} !== 6'b111110)
            $display("FAIL drain_exc: got %b required 111110",
                     {flush_d, flush_e, flush_m, flush_w, exc_pc_sel_f, stall_f});
        else n_pass++;
        tick();
        idle(); data_data_ok = 1;
        #1;
        n_checks++;
        if ({discard_data, stall_f, stall_d, stall_m} !== 4'b1100)
            $display("FAIL drain_discard: got %b required 1100", {discard_data, stall_f, stall_d, stall_m});
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if ({discard_data, stall_f} !== 2'b00) $display("FAIL drain_exit: got %b required 00", {discard_data, stall_f});
        else n_pass++;
        // exception with nothing outstanding does not enter DRAIN
        exception_m = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_f !== 1'b0) $display("FAIL drain_none: got %b required 0", stall_f);
        else n_pass++;
        // second exception while draining
        data_req_ok = 1; tick();
        idle(); exception_m = 1; tick();
        #1;
        n_checks++;
        if ({flush_d, flush_w, exc_pc_sel_f, stall_f} !== 4'b1111)
            $display("FAIL drain_reexc: got %b required 1111", {flush_d, flush_w, exc_pc_sel_f, stall_f});
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if ({stall_f, stall_d, discard_data} !== 3'b100)
            $display("FAIL drain_hold: got %b required 100", {stall_f, stall_d, discard_data});
        else n_pass++;
        data_data_ok = 1; tick();
        idle(); #1;
        n_checks++;
        if (stall_f !== 1'b0) $display("FAIL drain_exit2: got %b required 0", stall_f);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset();
        mdu_busy = 1;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (k == 1023 || k == 1024 || k == 1100) begin
                n_checks++;
                if (stall_timeout !== (k >= TIMEOUT))
                    $display("FAIL watchdog_k%0d: got %b required %b", k, stall_timeout, k >= TIMEOUT);
                else n_pass++;
            end
        end
        mdu_busy = 0; tick(); tick();
        n_checks++;
        if (stall_timeout !== 1'b1) $display("FAIL watchdog_sticky: got %b required 1", stall_timeout);
        else n_pass++;
        do_reset();
        n_checks++;
        if (stall_timeout !== 1'b0) $display("FAIL watchdog_reset: got %b required 0", stall_timeout);
        else n_pass++;
    endtask

    task automatic test_perf();
        int exp_mdu, exp_haz;
`ifdef HAZ_PERF_CNT_EN
        exp_mdu = 7; exp_haz = 3;
`else
        exp_mdu = 0; exp_haz = 0;
`endif
        do_reset();
        mdu_busy = 1;
        repeat (7) tick();
        exception_m = 1; tick();
        idle();
        write_reg_e = 4; reg_write_e = 1; branch_d = 1; rs_d = 4; use_rs_d = 1;
        repeat (3) tick();
        idle(); #1;
        n_checks++;
        if (perf_mdu !== 32'(exp_mdu)) $display("FAIL perf_mdu: got %0d required %0d", perf_mdu, exp_mdu);
        else n_pass++;
        n_checks++;
        if (perf_haz !== 32'(exp_haz)) $display("FAIL perf_haz: got %0d required %0d", perf_haz, exp_haz);
        else n_pass++;
        n_checks++;
        if (perf_mem !== 32'd0) $display("FAIL perf_mem: got %0d required 0", perf_mem);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [17:0] e;
        bit sf, se, sm;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            rs_d = 5'($urandom_range(0, 7));  rt_d = 5'($urandom_range(0, 7));
            rs_e = 5'($urandom_range(0, 7));  rt_e = 5'($urandom_range(0, 7));
            write_reg_e = 5'($urandom_range(0, 7));
            write_reg_m = 5'($urandom_range(0, 7));
            write_reg_w = 5'($urandom_range(0, 7));
            use_rs_d     = $urandom_range(0, 1) == 1;
            use_rt_d     = $urandom_range(0, 1) == 1;
            branch_d     = $urandom_range(0, 3) == 0;
            reg_write_e  = $urandom_range(0, 1) == 1;
            long_lat_e   = $urandom_range(0, 2) == 0;
            reg_write_m  = $urandom_range(0, 1) == 1;
            reg_write_w  = $urandom_range(0, 1) == 1;
            exception_m  = $urandom_range(0, 29) == 0;
            mdu_busy     = $urandom_range(0, 9) == 0;
            inst_req_ok  = $urandom_range(0, 3) == 0;
            inst_data_ok = $urandom_range(0, 3) == 0;
            data_req_ok  = $urandom_range(0, 3) == 0;
            data_data_ok = $urandom_range(0, 3) == 0;
            #1;
            model_outputs(e, sf, se, sm);
            n_checks++;
            if (obs !== e) $display("FAIL random_c%0d: got %b required %b", c, obs, e);
            else n_pass++;
            model_step(sf, se, sm);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        test_reset();
        test_forwarding();
        test_load_branch();
        test_outstanding();
        test_reset_mid();
        test_drain();
        test_watchdog();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
